drw_vramctrl_rd_mc: RTL and testbench

DRW_VRAMCTRL_RD_MC -- requirements
Module: drw_vramctrl_rd_mc

---
 rtl/drw_vramctrl_rd_mc.sv | 242 ++++++++++++++++++++++++
 tb/tb_drw_vramctrl_rd_mc.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drw_vramctrl_rd_mc.sv
// Multi-channel VRAM read controller: round-robin arbitration of per-channel burst
// requests onto a single AXI read port, routing returned beats to per-channel FIFOs.
module drw_vramctrl_rd_mc #(
  parameter int NCH    = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARST_N,
  input  logic                  RST,
  input  logic                  START,
  input  logic [NCH-1:0]        CH_EN,
  input  logic [NCH-1:0]        CH_RGB,
  input  logic [NCH-1:0]        REQ_VALID,
  input  logic [NCH*ADDR_W-1:0] REQ_ADDR,
  input  logic [NCH*8-1:0]      REQ_LEN,
  input  logic [NCH-1:0]        REQ_FIN,
  output logic [NCH-1:0]        REQ_ACK,
  input  logic [NCH-1:0]        FIFO_AFULL,
  output logic [NCH-1:0]        FIFO_WR,
  output logic [DATA_W-1:0]     FIFO_DIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [1:0]            ERR_CH,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_W-1:0]     ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic                  RLAST,
  input  logic [DATA_W-1:0]     RDATA,
  input  logic [1:0]            RRESP
);

  localparam int LANES = DATA_W / 32;

  typedef enum logic [2:0] {ST_IDLE, ST_ARB, ST_ADDR, ST_DATA, ST_DRAIN, ST_DONE} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          ch_reg, ch_next;
  logic [1:0]          last_reg, last_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [7:0]          len_reg, len_next;
  logic                fin_reg, fin_next;
  logic [7:0]          beat_reg, beat_next;
  logic [NCH-1:0]      done_reg, done_next;
  logic                err_reg, err_next;
  logic [1:0]          err_ch_reg, err_ch_next;
  logic                rst_pend_reg, rst_pend_next;

  logic [NCH-1:0]      eligible, ch_oh, done_upd;
  logic                grant_found, hi_found, lo_found;
  logic [1:0]          grant_idx, hi_idx, lo_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [7:0]          sel_len;
  logic                sel_fin;
  logic                cur_afull, cur_rgb, rd_fire, err_hit;
  logic [DATA_W-1:0]   din_masked;
  logic                unused_rresp0;

  assign unused_rresp0 = RRESP[0];
  assign ARSIZE        = 3'($clog2(DATA_W / 8));
  assign ARADDR        = addr_reg;
  assign ARLEN         = len_reg;
  assign ERR           = err_reg;
  assign ERR_CH        = err_ch_reg;

  assign eligible = CH_EN & REQ_VALID & ~done_reg & ~FIFO_AFULL;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_oh
      assign ch_oh[gi] = (ch_reg == 2'(gi));
    end
    // RGB textures carry no alpha: force the top byte of each 32-bit pixel lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign din_masked[32*gi +: 32] = {cur_rgb ? 8'hFF : RDATA[32*gi+24 +: 8], RDATA[32*gi +: 24]};
    end
  endgenerate

  assign cur_afull = |(FIFO_AFULL & ch_oh);
  assign cur_rgb   = |(CH_RGB & ch_oh);
  assign rd_fire   = RVALID & ~cur_afull;
  assign err_hit   = RRESP[1] | (RLAST & (beat_reg != len_reg)) | (~RLAST & (beat_reg == len_reg));
  assign FIFO_DIN  = (state_reg == ST_DATA) ? din_masked : '0;

  // Round-robin: lowest eligible index above the last grant, else lowest eligible overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (eligible[i] && (i > int'(last_reg))) begin
        hi_found = 1'b1;
        hi_idx   = 2'(i);
      end
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_idx   = 2'(i);
      end
    end
    grant_found = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_fin  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
        sel_len  = REQ_LEN[i*8 +: 8];
        sel_fin  = REQ_FIN[i];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ch_next       = ch_reg;
    last_next     = last_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    fin_next      = fin_reg;
    beat_next     = beat_reg;
    done_next     = done_reg;
    err_next      = err_reg;
    err_ch_next   = err_ch_reg;
    rst_pend_next = rst_pend_reg;
    done_upd      = done_reg;
    ARVALID       = 1'b0;
    RREADY        = 1'b0;
    FIFO_WR       = '0;
    REQ_ACK       = '0;
    BUSY          = 1'b0;
    DONE          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!RST && START && (|CH_EN)) begin
          state_next  = ST_ARB;
          done_next   = '0;
          err_next    = 1'b0;
          err_ch_next = '0;
        end
      end
      ST_ARB: begin
        BUSY = 1'b1;
        if (RST || !START) begin
          state_next = ST_IDLE;
        end else if (grant_found) begin
          ch_next    = grant_idx;
          last_next  = grant_idx;
          addr_next  = sel_addr;
          len_next   = sel_len;
          fin_next   = sel_fin;
          beat_next  = '0;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        BUSY    = 1'b1;
        ARVALID = 1'b1;
        if (RST) rst_pend_next = 1'b1;
        // An AR already presented must complete; a cleared command drains its data.
        if (ARREADY) begin
          if (RST || rst_pend_reg) begin
            rst_pend_next = 1'b0;
            state_next    = ST_DRAIN;
          end else begin
            REQ_ACK    = ch_oh;
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        BUSY = 1'b1;
        if (RST) begin
          RREADY     = 1'b1;
          state_next = (RVALID && RLAST) ? ST_IDLE : ST_DRAIN;
        end else begin
          RREADY = ~cur_afull;
          if (rd_fire) begin
            FIFO_WR   = ch_oh;
            beat_next = beat_reg + 8'd1;
            if (err_hit) begin
              err_next = 1'b1;
              if (!err_reg) err_ch_next = ch_reg;
            end
            if (RLAST) begin
              done_upd   = done_reg | (fin_reg ? ch_oh : '0);
              done_next  = done_upd;
              state_next = (&(done_upd | ~CH_EN)) ? ST_DONE : ST_ARB;
            end
          end
        end
      end
      ST_DRAIN: begin
        BUSY   = 1'b1;
        RREADY = 1'b1;
        if (RVALID && RLAST) state_next = ST_IDLE;
      end
      ST_DONE: begin
        DONE = 1'b1;
        if (RST || !START) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_reg    <= ST_IDLE;
      ch_reg       <= '0;
      last_reg     <= 2'(NCH - 1);
      addr_reg     <= '0;
      len_reg      <= '0;
      fin_reg      <= 1'b0;
      beat_reg     <= '0;
      done_reg     <= '0;
      err_reg      <= 1'b0;
      err_ch_reg   <= '0;
      rst_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ch_reg       <= ch_next;
      last_reg     <= last_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      fin_reg      <= fin_next;
      beat_reg     <= beat_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      err_ch_reg   <= err_ch_next;
      rst_pend_reg <= rst_pend_next;
    end
  end

endmodule

// File: tb/tb_drw_vramctrl_rd_mc.sv
// Scoreboard bench: mkaddr + AXI slave models drive the controller, a monitor pops
// expected AR commands and FIFO writes pushed by the directed scenarios.
module tb_drw_vramctrl_rd_mc;
  localparam int NCH = 2;
  localparam int DW  = 64;
  localparam int AW  = 32;

  logic              ACLK = 1'b0, ARST_N = 1'b0, RST = 1'b0, START = 1'b0;
  logic [NCH-1:0]    CH_EN = '0, CH_RGB = '0, REQ_VALID = '0, REQ_FIN = '0, FIFO_AFULL = '0;
  logic [NCH*AW-1:0] REQ_ADDR = '0;
  logic [NCH*8-1:0]  REQ_LEN = '0;
  logic              ARREADY = 1'b0, RVALID = 1'b0, RLAST = 1'b0;
  logic [DW-1:0]     RDATA = '0;
  logic [1:0]        RRESP = '0;
  logic [NCH-1:0]    REQ_ACK, FIFO_WR;
  logic [DW-1:0]     FIFO_DIN;
  logic              BUSY, DONE, ERR, ARVALID, RREADY;
  logic [1:0]        ERR_CH;
  logic [AW-1:0]     ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;

  drw_vramctrl_rd_mc #(.NCH(NCH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .ACLK(ACLK), .ARST_N(ARST_N), .RST(RST), .START(START), .CH_EN(CH_EN), .CH_RGB(CH_RGB),
    .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .REQ_FIN(REQ_FIN),
    .REQ_ACK(REQ_ACK), .FIFO_AFULL(FIFO_AFULL), .FIFO_WR(FIFO_WR), .FIFO_DIN(FIFO_DIN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CH(ERR_CH), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .RVALID(RVALID), .RREADY(RREADY),
    .RLAST(RLAST), .RDATA(RDATA), .RRESP(RRESP)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct { int ch; logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { int ch; logic [63:0] data; } wr_t;
  ar_t exp_ar[$];
  wr_t exp_wr[$];

  function automatic logic [63:0] beat_data(input logic [31:0] addr, input int b);
    return 64'h1122334455667788 + {addr, 24'h0, 8'(b)};
  endfunction

  function automatic logic [1:0] oh(input int ch);
    return 2'(1 << ch);
  endfunction

  // mkaddr model tables
  logic [31:0] tab_addr [NCH][4];
  int          tab_len  [NCH];
  int          rcnt [NCH] = '{0, 0};
  int          ridx [NCH] = '{0, 0};

  // AXI slave model state and fault-injection knobs
  logic        ar_tog = 1'b0;
  logic        s_busy = 1'b0;
  logic [31:0] s_addr = '0;
  int s_beat = 0, s_last = 0, s_ar = 0, ar_n = 0;
  int bad_ar = -1, bad_beat = 0, early_ar = -1, early_beat = 0;
  int rst_ar = -1, rst_beat = 0, af_ar = -1, af_beat = 0, afull_cnt = 0;
  logic rst_now = 1'b0, rst_fired = 1'b0;

  // monitor statistics
  int wr_cnt = 0, af_low = 0, drain_n = 0;
  logic [63:0] cap0 = '0;
  logic cap_valid = 1'b0;

  task automatic set_chan(input int c, input int n, input int len);
    rcnt[c] = n;
    ridx[c] = 0;
    tab_len[c] = len;
    for (int k = 0; k < 4; k++) tab_addr[c][k] = 32'(c * 'h1000 + k * 'h100);
  endtask

  task automatic add_burst(input int ch, input logic [31:0] addr, input int len, input int nwr, input logic rgb);
    ar_t a;
    wr_t w;
    logic [63:0] d;
    a.ch = ch; a.addr = addr; a.len = 8'(len);
    exp_ar.push_back(a);
    for (int b = 0; b < nwr; b++) begin
      d = beat_data(addr, b);
      w.ch = ch;
      w.data = rgb ? {8'hFF, d[55:32], 8'hFF, d[23:0]} : d;
      exp_wr.push_back(w);
    end
  endtask

  task automatic clear_knobs();
    bad_ar = -1; early_ar = -1; rst_ar = -1; af_ar = -1; ar_n = 0; wr_cnt = 0;
  endtask

  // Drivers: change inputs on negedge, observe handshakes just before the posedge.
  initial begin
    int k;
    logic busy_before;
    forever begin
      @(negedge ACLK);
      for (int c = 0; c < NCH; c++) begin
        k = (ridx[c] < rcnt[c]) ? ridx[c] : 0;
        REQ_VALID[c] = (ridx[c] < rcnt[c]);
        REQ_ADDR[c*AW +: AW] = tab_addr[c][k];
        REQ_LEN[c*8 +: 8] = 8'(tab_len[c]);
        REQ_FIN[c] = (ridx[c] == rcnt[c] - 1);
      end
      ARREADY = ar_tog;
      RVALID = s_busy;
      RDATA = s_busy ? beat_data(s_addr, s_beat) : '0;
      RLAST = s_busy && (s_beat == s_last);
      RRESP = (s_busy && s_ar == bad_ar && s_beat == bad_beat) ? 2'b10 : 2'b00;
      FIFO_AFULL = {(afull_cnt > 0), 1'b0};
      RST = rst_now;
      #4;
      ar_tog = ~ar_tog;
      rst_now = 1'b0;
      if (afull_cnt > 0) afull_cnt--;
      busy_before = s_busy;
      if (RVALID && RREADY) begin
        if (s_ar == rst_ar && s_beat == rst_beat) begin rst_now = 1'b1; rst_fired = 1'b1; end
        if (s_ar == af_ar && s_beat == af_beat) afull_cnt = 5;
        if (RLAST) s_busy = 1'b0; else s_beat++;
      end
      if (ARVALID && ARREADY) begin
        chk("one_outstanding", 64'(busy_before), 64'd0);
        s_busy = 1'b1; s_addr = ARADDR; s_beat = 0; s_ar = ar_n;
        s_last = (ar_n == early_ar) ? early_beat : int'(ARLEN);
        ar_n++;
      end
      for (int c = 0; c < NCH; c++) if (REQ_ACK[c]) ridx[c]++;
    end
  end

  // Monitor / scoreboard
  initial begin
    ar_t a;
    wr_t w;
    logic pend = 1'b0;
    logic [31:0] paddr = '0;
    logic [7:0] plen = '0;
    forever begin
      @(negedge ACLK);
      #4;
      if (pend) chk("ar_stable", {23'd0, ARVALID, ARADDR, ARLEN}, {23'd0, 1'b1, paddr, plen});
      pend = ARVALID && !ARREADY;
      paddr = ARADDR; plen = ARLEN;
      if (ARVALID && ARREADY) begin
        if (exp_ar.size() == 0) begin
          checks++; failures++;
          $display("FAIL ar_unexpected actual addr=%0h required=no AR", ARADDR);
        end else begin
          a = exp_ar.pop_front();
          $display("AR ch=%0d addr=%0h len=%0d", a.ch, ARADDR, ARLEN);
          chk("ar_addr", 64'(ARADDR), 64'(a.addr));
          chk("ar_len", 64'(ARLEN), 64'(a.len));
          chk("ar_size", 64'(ARSIZE), 64'd3);
          chk("req_ack", 64'(REQ_ACK), 64'(oh(a.ch)));
        end
      end
      if (FIFO_WR != '0) begin
        wr_cnt++;
        if (FIFO_WR[0] && !cap_valid) begin cap0 = FIFO_DIN; cap_valid = 1'b1; end
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected actual wr=%b din=%0h required=no write", FIFO_WR, FIFO_DIN);
        end else begin
          w = exp_wr.pop_front();
          $display("WR ch=%0d din=%0h", w.ch, FIFO_DIN);
          chk("wr_ch", 64'(FIFO_WR), 64'(oh(w.ch)));
          chk("wr_data", FIFO_DIN, w.data);
        end
      end
      if (FIFO_AFULL[1] && !RREADY) af_low++;
      if (RVALID && RREADY && FIFO_WR == '0) drain_n++;
    end
  end

  task automatic wait_done(input string name, input int budget);
    int t = 0;
    while (!DONE && t < budget) begin @(negedge ACLK); t++; end
    chk({name, "_done_reached"}, 64'(DONE), 64'd1);
    chk({name, "_busy_in_done"}, 64'(BUSY), 64'd0);
  endtask

  task automatic end_cmd(input string name);
    START = 1'b0;
    @(negedge ACLK);
    chk({name, "_done_clear"}, 64'(DONE), 64'd0);
    chk({name, "_ar_left"}, 64'(exp_ar.size()), 64'd0);
    chk({name, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge ACLK);
    chk("rst_outputs", {51'd0, ARVALID, RREADY, FIFO_WR, REQ_ACK, BUSY, DONE, ERR, ERR_CH},  64'd0);
    chk("rst_araddr", {24'd0, ARADDR, ARLEN}, 64'd0);
    chk("rst_arsize", 64'(ARSIZE), 64'd3);
    ARST_N = 1'b1;
    @(negedge ACLK);

    // A: two channels, three LEN=3 bursts each, alternating grants
    clear_knobs(); CH_RGB = 2'b00; CH_EN = 2'b11;
    set_chan(0, 3, 3); set_chan(1, 3, 3);
    for (int n = 0; n < 3; n++) begin
      add_burst(0, 32'(n * 'h100), 3, 4, 1'b0);
      add_burst(1, 32'('h1000 + n * 'h100), 3, 4, 1'b0);
    end
    START = 1'b1;
    wait_done("A", 600);
    chk("A_wr_count", 64'(wr_cnt), 64'd24);
    chk("A_ar_count", 64'(ar_n), 64'd6);
    chk("A_err", 64'(ERR), 64'd0);
    end_cmd("A");

    // B: RGB alpha forcing on ch0, FIFO almost-full stall on ch1
    clear_knobs(); CH_RGB = 2'b01; CH_EN = 2'b11;
    set_chan(0, 1, 1); set_chan(1, 1, 7);
    af_ar = 1; af_beat = 2; af_low = 0; cap_valid = 1'b0;
    add_burst(0, 32'h0, 1, 2, 1'b1);
    add_burst(1, 32'h1000, 7, 8, 1'b0);
    START = 1'b1;
    wait_done("B", 600);
    chk("B_rgb_din", cap0, 64'hFF223344FF667788);
    chk("B_rready_low", 64'(af_low), 64'd5);
    chk("B_wr_count", 64'(wr_cnt), 64'd10);
    chk("B_err", 64'(ERR), 64'd0);
    end_cmd("B");

    // C: SLVERR on beat 2 of ch1
    clear_knobs(); CH_RGB = 2'b00; CH_EN = 2'b11;
    set_chan(0, 1, 3); set_chan(1, 1, 3);
    bad_ar = 1; bad_beat = 2;
    add_burst(0, 32'h0, 3, 4, 1'b0);
    add_burst(1, 32'h1000, 3, 4, 1'b0);
    START = 1'b1;
    wait_done("C", 600);
    chk("C_err", 64'(ERR), 64'd1);
    chk("C_err_ch", 64'(ERR_CH), 64'd1);
    chk("C_wr_count", 64'(wr_cnt), 64'd8);
    end_cmd("C");
    chk("C_err_held_idle", 64'(ERR), 64'd1);

    // D: early RLAST on beat 1 of a LEN=3 burst
    clear_knobs(); CH_EN = 2'b01;
    set_chan(0, 2, 3); set_chan(1, 0, 3);
    early_ar = 0; early_beat = 1;
    add_burst(0, 32'h0, 3, 2, 1'b0);
    add_burst(0, 32'h100, 3, 4, 1'b0);
    START = 1'b1;
    @(negedge ACLK);
    chk("D_err_cleared", 64'(ERR), 64'd0);
    wait_done("D", 600);
    chk("D_err", 64'(ERR), 64'd1);
    chk("D_err_ch", 64'(ERR_CH), 64'd0);
    chk("D_wr_count", 64'(wr_cnt), 64'd6);
    end_cmd("D");

    // E: soft clear during DATA after beat 1 of LEN=7
    clear_knobs(); CH_EN = 2'b10;
    set_chan(0, 0, 3); set_chan(1, 1, 7);
    rst_ar = 0; rst_beat = 1; rst_fired = 1'b0; drain_n = 0;
    add_burst(1, 32'h1000, 7, 2, 1'b0);
    START = 1'b1;
    t = 0;
    while (!rst_fired && t < 200) begin @(negedge ACLK); t++; end
    chk("E_rst_reached", 64'(rst_fired), 64'd1);
    START = 1'b0;
    t = 0;
    do begin @(negedge ACLK); t++; end while (BUSY && t < 200);
    chk("E_idle", 64'(BUSY), 64'd0);
    chk("E_drain_beats", 64'(drain_n), 64'd6);
    chk("E_wr_count", 64'(wr_cnt), 64'd2);
    chk("E_done", 64'(DONE), 64'd0);
    chk("E_err", 64'(ERR), 64'd0);
    chk("E_wr_left", 64'(exp_wr.size()), 64'd0);

    // F: ARB holds with nothing eligible, leaves when START falls
    clear_knobs(); CH_EN = 2'b01;
    set_chan(0, 0, 3); set_chan(1, 0, 3);
    START = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("F_arb_hold", 64'(BUSY), 64'd1);
    START = 1'b0;
    @(negedge ACLK);
    chk("F_arb_exit", 64'(BUSY), 64'd0);
    chk("F_no_ar", 64'(ar_n), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
